rvv_backend_rs_fifo: RTL

Reservation-station FIFO sitting directly downstream of the dispatch stage: one instance per execution unit (ALU, MUL/MAC, PMT/RDT/CMP, DIV, LSU, LSU mapinfo). Accepts up to `NUM_DP_UOP` uops per cycle on per-port valid/ready pushes, compacts them in port order, and presents them in order to the execution unit on a single valid/ready pop port. Supports a synchronous flush from the ROB trap path.

---
 rtl/rvv_backend_rs_fifo_pkg.sv | 10 +
 rtl/rvv_backend_rs_compact.sv | 23 ++
 rtl/rvv_backend_rs_fifo.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rvv_backend_rs_fifo_pkg.sv
// Shared sizing for the reservation-station FIFOs: dispatch width and default payload type.
package rvv_backend_rs_fifo_pkg;

  localparam int unsigned NUM_DP_UOP = 2;

  typedef logic [63:0] rs_payload_t;

  localparam int unsigned RS_DW = $bits(rs_payload_t);

endpackage

// File: rtl/rvv_backend_rs_compact.sv
// Turns the accepted push mask into per-port slot offsets (exclusive prefix popcount) and a total.
module rvv_backend_rs_compact #(
  parameter int unsigned NP = 2,
  parameter int unsigned OW = 3,
  parameter int unsigned CW = 4
) (
  input  logic [NP-1:0]         mask_i,
  output logic [NP-1:0][OW-1:0] offset_o,
  output logic [CW-1:0]         npush_o
);

  always_comb begin
    logic [CW-1:0] acc;
    acc      = '0;
    offset_o = '0;
    for (int i = 0; i < NP; i++) begin
      offset_o[i] = acc[OW-1:0];
      acc         = acc + CW'(mask_i[i]);
    end
    npush_o = acc;
  end

endmodule

// File: rtl/rvv_backend_rs_fifo.sv
// Multi-push, single-pop reservation-station FIFO with synchronous flush.
// Define RS_FIFO_BYPASS_EN for a zero-cycle push-to-pop path when the FIFO is empty.
module rvv_backend_rs_fifo
  import rvv_backend_rs_fifo_pkg::*;
#(
  parameter int unsigned DW    = RS_DW,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NP    = NUM_DP_UOP
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NP-1:0]          push_valid_i,
  input  logic [NP-1:0][DW-1:0]  push_data_i,
  output logic [NP-1:0]          push_ready_o,
  output logic                   pop_valid_o,
  output logic [DW-1:0]          pop_data_o,
  input  logic                   pop_ready_i,
  input  logic                   flush_i,
  output logic                   fifo_empty_o,
  output logic                   fifo_full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0]         mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         free_slots;
  logic [NP-1:0]         accepted;
  logic [NP-1:0]         write_mask;
  logic [NP-1:0][AW-1:0] offset;
  logic [CW-1:0]         nwrite;
  logic                  mem_valid;
  logic                  mem_pop;

  assign free_slots = CW'(DEPTH) - count_q;
  assign mem_valid  = (count_q != '0);

  // Space check uses only the registered count; a same-cycle pop never frees a slot.
  always_comb begin
    push_ready_o = '0;
    for (int i = 0; i < NP; i++) begin
      push_ready_o[i] = ~flush_i & (free_slots >= CW'(i + 1));
    end
  end

  assign accepted = push_valid_i & push_ready_o;

`ifdef RS_FIFO_BYPASS_EN
  logic [NP-1:0] byp_sel;
  logic [DW-1:0] byp_data;
  logic          byp_take;

  assign byp_sel  = accepted & (~accepted + NP'(1));
  assign byp_take = ~flush_i & ~mem_valid & (|accepted) & pop_ready_i;

  always_comb begin
    byp_data = '0;
    for (int i = 0; i < NP; i++) begin
      if (byp_sel[i]) byp_data = push_data_i[i];
    end
  end

  assign pop_valid_o = ~flush_i & (mem_valid | (|accepted));
  assign pop_data_o  = mem_valid ? mem_q[rptr_q] : byp_data;
  assign write_mask  = byp_take ? (accepted & ~byp_sel) : accepted;
  assign mem_pop     = ~flush_i & mem_valid & pop_ready_i;
`else
  assign pop_valid_o = ~flush_i & mem_valid;
  assign pop_data_o  = mem_q[rptr_q];
  assign write_mask  = accepted;
  assign mem_pop     = pop_valid_o & pop_ready_i;
`endif

  rvv_backend_rs_compact #(
    .NP (NP),
    .OW (AW),
    .CW (CW)
  ) u_compact (
    .mask_i   (write_mask),
    .offset_o (offset),
    .npush_o  (nwrite)
  );

  always_comb begin
    wptr_d  = wptr_q + AW'(nwrite);
    rptr_d  = rptr_q + AW'(mem_pop);
    count_d = count_q + nwrite - CW'(mem_pop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage is not reset; write_mask is already zero during flush.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NP; i++) begin
      if (write_mask[i]) mem_q[AW'(wptr_q + offset[i])] <= push_data_i[i];
    end
  end

  assign fifo_empty_o = (count_q == '0);
  assign fifo_full_o  = (count_q == CW'(DEPTH));

`ifndef SYNTHESIS
  push_protocol_a : assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    ((push_valid_i & ~push_ready_o) == '0));
`endif

endmodule
